tlm_hdl2hvl_arb: RTL and testbench
==================================

# tlm_hdl2hvl_arb

Round-robin arbiter with burst locking that shares one `tlm_hdl2hvl_fifo` input among `Nreq` HDL-side producers. It sits between several ready/valid producers and the fifo's `valid`/`ready`/`dat_i` port. Accepted beats pass through a single registered output stage. Each beat is tagged with its source index so the HVL side can demultiplex.

## Interface
- `Nreq`, 4: number of requesters, 2..16.
- `Twidth`, 32: data width.
- `Tburst`, 2: maximum consecutive beats granted to one requester before rotation; 1 gives pure round-robin.
- `IDW`, `$clog2(Nreq)`: width of the source tag; derived, not overridden.

Ports:
- `clock`: in, 1. Sole clock; all state changes on its rising edge.
- `reset`: in, 1. Asynchronous, active-high.
- `req_valid`: in, `Nreq`. Per-requester valid.
- `req_ready`: out, `Nreq`. Per-requester ready; at most one bit is set.
- `req_dat`: in, `Nreq*Twidth`. Requester i occupies bits `[i*Twidth +: Twidth]`.
- `valid`: out, 1. Output beat valid; connects to fifo `valid`.
- `ready`: in, 1. Downstream ready; connects to fifo `ready`.
- `dat_o`: out, `Twidth`. Output data; connects to fifo `dat_i`.
- `id_o`: out, `IDW`. Source index of the current `dat_o`.

## Operation
- State registers:
  - `valid_q`, `dat_q`, `id_q`: output stage.
  - `cur_q`: locked owner.
  - `lock_q`: lock active.
  - `cnt_q`: beats in the current burst, `$clog2(Tburst+1)` bits.
  - `last_q`: last granted index.
- Reset values: `valid`=0, `dat_o`=0, `id_o`=0, `cur_q`=0, `lock_q`=0, `cnt_q`=0, `last_q`=`Nreq`-1 so that requester 0 has first priority. While `reset` is high, `req_ready` is all zeros.
- `load_en` = `!valid_q || ready`. The output stage may take a new beat this cycle.
- Arbitration states:
  - LOCKED (`lock_q`=1): if `req_valid[cur_q]` is high, `sel`=`cur_q`.
  - OPEN: active when `lock_q`=0, or when the locked owner has dropped `req_valid`. `sel` is the first i with `req_valid[i]` set, scanning `last_q+1`, `last_q+2`, … modulo `Nreq`.
- `req_ready[i]` = `load_en && (i==sel) && (req_valid` has any bit set`)`. A beat is accepted when `req_valid[sel] && req_ready[sel]`.
- On acceptance:
  - `dat_q` <= `req_dat[sel]`, `id_q` <= `sel`, `valid_q` <= 1, `last_q` <= `sel`.
  - If the arbiter was LOCKED with `sel==cur_q`, `cnt_q` <= `cnt_q+1`. Otherwise `cnt_q` <= 1 and `cur_q` <= `sel`.
  - `lock_q` <= (new `cnt_q` < `Tburst`).
- `load_en` high, no request pending: `valid_q` <= 0. Lock state is held, but the lock is broken if the owner is not valid; in that case `lock_q` <= 0.
- `load_en` low: all state holds. `dat_o` and `id_o` stay stable while `valid && !ready`.
- Lock expiry with only the same requester valid: the round-robin scan re-selects it, `cnt_q` restarts at 1, and there is no bubble.
- Locked owner drops `req_valid`: in the same cycle, the round-robin scan starts at `cur_q+1`. The owner does not regain priority.

## Timing
- Latency is 1 cycle from acceptance at a `req_*` handshake to `valid`/`dat_o`/`id_o`.
- Throughput is 1 beat per cycle when `ready` is held high. No bubble occurs on owner change or lock expiry.
- `req_ready` is combinational from `ready`, `req_valid` and state. It has no combinational dependence on `req_dat`.
- Asserting `reset` clears `valid` immediately, without waiting for a clock edge. Any in-flight output beat is discarded.

## Test plan
- Reset: hold `reset` for 3 cycles with all `req_valid`=1. Require `valid`=0, `dat_o`=0, `id_o`=0 and `req_ready`=0 throughout. After release, the first accepted beat comes from requester 0.
- Full contention: `Nreq`=4, `Tburst`=2, all requesters valid, requester i sends `0x100*i + k`, `ready`=1.
  - `id_o` sequence: 0,0,1,1,2,2,3,3,0,0.
  - `dat_o`: 0x000, 0x001, 0x100, 0x101, and so on.
  - One beat per cycle.
- Single requester: only requester 2 valid, sending 0x10..0x19. Require 10 consecutive beats with `id_o`=2, data in order, and no idle cycles across lock expiry.
- Backpressure: with `valid`=1 and `dat_o`=0x101, drop `ready` for 5 cycles.
  - `dat_o` and `id_o` stay stable and `req_ready`=0 throughout.
  - After `ready` returns, the next beat is 0x200 with no loss or duplication.
- Owner drop: requesters 1 and 3 valid. Requester 1 sends one beat, then deasserts `req_valid`. The next grant goes to 3, and `cnt_q` restarts at 1.
- Mid-burst reset: assert `reset` asynchronously while `valid`=1. `valid` falls before the next edge. After release, arbitration restarts at requester 0.

Source files
------------

// File: rtl/tlm_hdl2hvl_arb_if.sv
// Bundle between HDL-side producers, the arbiter and the fifo input port.
// The arbiter takes the slave view; producers/fifo (or a bench) take master.
interface tlm_hdl2hvl_arb_if #(
    parameter int Nreq   = 4,
    parameter int Twidth = 32
);
    localparam int IDW = $clog2(Nreq);

    logic [Nreq-1:0]        req_valid;
    logic [Nreq-1:0]        req_ready;
    logic [Nreq*Twidth-1:0] req_dat;
    logic                   valid;
    logic                   ready;
    logic [Twidth-1:0]      dat_o;
    logic [IDW-1:0]         id_o;

    modport master (
        output req_valid, req_dat, ready,
        input  req_ready, valid, dat_o, id_o
    );

    modport slave (
        input  req_valid, req_dat, ready,
        output req_ready, valid, dat_o, id_o
    );
endinterface

// File: rtl/tlm_hdl2hvl_arb.sv
// Round-robin arbiter with burst locking feeding one fifo input through a
// single registered output stage; each beat carries its source index.
module tlm_hdl2hvl_arb #(
    parameter int Nreq   = 4,
    parameter int Twidth = 32,
    parameter int Tburst = 2
) (
    input logic              clock,
    input logic              reset,
    tlm_hdl2hvl_arb_if.slave bus
);
    localparam int IDW = $clog2(Nreq);
    localparam int CW  = $clog2(Tburst + 1);

    typedef enum logic {OPEN, LOCKED} lock_t;

    lock_t             state_reg, state_next;
    logic              valid_reg, valid_next;
    logic [Twidth-1:0] dat_reg,   dat_next;
    logic [IDW-1:0]    id_reg,    id_next;
    logic [IDW-1:0]    cur_reg,   cur_next;
    logic [IDW-1:0]    last_reg,  last_next;
    logic [CW-1:0]     cnt_reg,   cnt_next;

    logic [Twidth-1:0] lane [Nreq];
    logic              load_en, any_valid, owner_hit, found;
    logic [IDW-1:0]    rr_sel, sel, scan_idx;

    for (genvar gi = 0; gi < Nreq; gi++) begin : g_lane
        assign lane[gi] = bus.req_dat[gi*Twidth +: Twidth];
    end

    // Selection: stay with the owner while it is locked and still valid,
    // otherwise scan round-robin starting just after the last grant.
    always_comb begin
        load_en   = !valid_reg || bus.ready;
        any_valid = |bus.req_valid;
        owner_hit = (state_reg == LOCKED) && bus.req_valid[cur_reg];
        rr_sel    = last_reg;
        found     = 1'b0;
        scan_idx  = '0;
        for (int k = 1; k <= Nreq; k++) begin
            scan_idx = (int'(last_reg) + k >= Nreq) ? IDW'(int'(last_reg) + k - Nreq)
                                                    : IDW'(int'(last_reg) + k);
            if (!found && bus.req_valid[scan_idx]) begin
                rr_sel = scan_idx;
                found  = 1'b1;
            end
        end
        sel = owner_hit ? cur_reg : rr_sel;
    end

    always_comb begin
        bus.req_ready = '0;
        if (load_en && any_valid && !reset)
            bus.req_ready = Nreq'(1) << sel;
    end

    always_comb begin
        state_next = state_reg;
        valid_next = valid_reg;
        dat_next   = dat_reg;
        id_next    = id_reg;
        cur_next   = cur_reg;
        last_next  = last_reg;
        cnt_next   = cnt_reg;
        if (load_en && any_valid) begin
            valid_next = 1'b1;
            dat_next   = lane[sel];
            id_next    = sel;
            last_next  = sel;
            if (owner_hit) begin
                cnt_next = cnt_reg + CW'(1);
            end else begin
                cnt_next = CW'(1);
                cur_next = sel;
            end
            state_next = (cnt_next < CW'(Tburst)) ? LOCKED : OPEN;
        end else if (load_en) begin
            valid_next = 1'b0;
            if (!owner_hit)
                state_next = OPEN;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= OPEN;
            valid_reg <= 1'b0;
            dat_reg   <= '0;
            id_reg    <= '0;
            cur_reg   <= '0;
            last_reg  <= IDW'(Nreq - 1);
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            valid_reg <= valid_next;
            dat_reg   <= dat_next;
            id_reg    <= id_next;
            cur_reg   <= cur_next;
            last_reg  <= last_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign bus.valid = valid_reg;
    assign bus.dat_o = dat_reg;
    assign bus.id_o  = id_reg;
endmodule

// File: tb/tb_tlm_hdl2hvl_arb.sv
// Self-checking bench for tlm_hdl2hvl_arb: directed scenarios plus a random
// run, all checked against a grant-rule model kept in the bench.
module tb_tlm_hdl2hvl_arb;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TB = 2;

    logic clock;
    logic reset;

    tlm_hdl2hvl_arb_if #(.Nreq(N), .Twidth(W)) bus();

    tlm_hdl2hvl_arb #(.Nreq(N), .Twidth(W), .Tburst(TB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors;
    int miscompares;

    // model state
    bit          m_valid;
    logic [W-1:0] m_dat;
    int          m_id, m_cur, m_cnt, m_last;
    bit          m_lock;
    int          base [N];
    int          kcnt [N];
    logic [N-1:0] exp_ready, obs_ready;

    task automatic model_reset();
        m_valid = 0; m_dat = '0; m_id = 0; m_cur = 0; m_lock = 0; m_cnt = 0;
        m_last = N - 1;
        for (int i = 0; i < N; i++) kcnt[i] = 0;
    endtask

    task automatic set_bases(input int stride);
        for (int i = 0; i < N; i++) base[i] = stride * i;
    endtask

    task automatic drive_data();
        for (int i = 0; i < N; i++) bus.req_dat[i*W +: W] = W'(base[i] + kcnt[i]);
    endtask

    // One cycle: drive at negedge, sample req_ready, advance model, sample outputs after posedge.
    task automatic step(input logic [N-1:0] mask, input logic rdy);
        bit load, anyv, hit;
        int sel;
        @(negedge clock);
        bus.req_valid = mask;
        bus.ready     = rdy;
        drive_data();
        #1 obs_ready = bus.req_ready;
        load = !m_valid || rdy;
        anyv = (mask != '0);
        hit  = m_lock && mask[m_cur];
        sel  = m_cur;
        if (!hit) begin
            for (int k = N; k >= 1; k--)
                if (mask[(m_last + k) % N]) sel = (m_last + k) % N;
        end
        exp_ready = '0;
        if (load && anyv) begin
            exp_ready[sel] = 1'b1;
            m_dat = W'(base[sel] + kcnt[sel]);
            kcnt[sel]++;
            m_id = sel; m_valid = 1; m_last = sel;
            if (hit) m_cnt++;
            else begin m_cnt = 1; m_cur = sel; end
            m_lock = (m_cnt < TB);
        end else if (load) begin
            m_valid = 0;
            if (m_lock && !mask[m_cur]) m_lock = 0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        bus.req_valid = '1;
        bus.ready = 1'b1;
        repeat (3) @(negedge clock);
        bus.req_valid = '0;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        set_bases(32'h100);
        @(negedge clock);
        reset = 1'b1;
        bus.req_valid = '1;
        bus.ready = 1'b1;
        drive_data();
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            vectors += 4;
            if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b expected 0", bus.valid); end
            if (bus.dat_o !== '0) begin miscompares++; $display("FAIL reset_dat: got %0h expected 0", bus.dat_o); end
            if (bus.id_o !== '0) begin miscompares++; $display("FAIL reset_id: got %0d expected 0", bus.id_o); end
            if (bus.req_ready !== '0) begin miscompares++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
        end
        @(negedge clock);
        bus.req_valid = '0;
        reset = 1'b0;
        model_reset();
        step(4'hF, 1'b1);
        vectors += 2;
        if (bus.id_o !== 2'd0) begin miscompares++; $display("FAIL reset_first_id: got %0d expected 0", bus.id_o); end
        if (bus.dat_o !== 32'h0) begin miscompares++; $display("FAIL reset_first_dat: got %0h expected 0", bus.dat_o); end
    endtask

    task automatic test_contention();
        int ids [10];
        logic [W-1:0] dats [10];
        ids  = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        dats = '{32'h000, 32'h001, 32'h100, 32'h101, 32'h200, 32'h201, 32'h300, 32'h301, 32'h002, 32'h003};
        set_bases(32'h100);
        do_reset();
        for (int n = 0; n < 10; n++) begin
            step(4'hF, 1'b1);
            vectors += 4;
            if (obs_ready !== exp_ready) begin miscompares++; $display("FAIL contention_ready[%0d]: got %b expected %b", n, obs_ready, exp_ready); end
            if (bus.valid !== 1'b1) begin miscompares++; $display("FAIL contention_valid[%0d]: got %0b expected 1", n, bus.valid); end
            if (bus.id_o !== 2'(ids[n])) begin miscompares++; $display("FAIL contention_id[%0d]: got %0d expected %0d", n, bus.id_o, ids[n]); end
            if (bus.dat_o !== dats[n]) begin miscompares++; $display("FAIL contention_dat[%0d]: got %0h expected %0h", n, bus.dat_o, dats[n]); end
        end
    endtask

    task automatic test_single();
        set_bases(32'h100);
        base[2] = 32'h10;
        do_reset();
        for (int n = 0; n < 10; n++) begin
            step(4'b0100, 1'b1);
            vectors += 4;
            if (obs_ready !== 4'b0100) begin miscompares++; $display("FAIL single_ready[%0d]: got %b expected 0100", n, obs_ready); end
            if (bus.valid !== 1'b1) begin miscompares++; $display("FAIL single_valid[%0d]: got %0b expected 1", n, bus.valid); end
            if (bus.id_o !== 2'd2) begin miscompares++; $display("FAIL single_id[%0d]: got %0d expected 2", n, bus.id_o); end
            if (bus.dat_o !== W'(32'h10 + n)) begin miscompares++; $display("FAIL single_dat[%0d]: got %0h expected %0h", n, bus.dat_o, 32'h10 + n); end
        end
    endtask

    task automatic test_backpressure();
        set_bases(32'h100);
        do_reset();
        repeat (4) step(4'hF, 1'b1);
        vectors++;
        if (bus.dat_o !== 32'h101) begin miscompares++; $display("FAIL bp_setup_dat: got %0h expected 101", bus.dat_o); end
        for (int n = 0; n < 5; n++) begin
            step(4'hF, 1'b0);
            vectors += 4;
            if (obs_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_ready[%0d]: got %b expected 0000", n, obs_ready); end
            if (bus.valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid[%0d]: got %0b expected 1", n, bus.valid); end
            if (bus.dat_o !== 32'h101) begin miscompares++; $display("FAIL bp_dat[%0d]: got %0h expected 101", n, bus.dat_o); end
            if (bus.id_o !== 2'd1) begin miscompares++; $display("FAIL bp_id[%0d]: got %0d expected 1", n, bus.id_o); end
        end
        step(4'hF, 1'b1);
        vectors += 2;
        if (bus.dat_o !== 32'h200) begin miscompares++; $display("FAIL bp_resume_dat: got %0h expected 200", bus.dat_o); end
        if (bus.id_o !== 2'd2) begin miscompares++; $display("FAIL bp_resume_id: got %0d expected 2", bus.id_o); end
        step(4'hF, 1'b1);
        vectors++;
        if (bus.dat_o !== 32'h201) begin miscompares++; $display("FAIL bp_next_dat: got %0h expected 201", bus.dat_o); end
    endtask

    task automatic test_owner_drop();
        logic [N-1:0] masks [4];
        int ids [4];
        masks = '{4'b1010, 4'b1000, 4'b1010, 4'b1010};
        ids   = '{1, 3, 3, 1};
        set_bases(32'h100);
        do_reset();
        for (int n = 0; n < 4; n++) begin
            step(masks[n], 1'b1);
            vectors += 2;
            if (obs_ready !== exp_ready) begin miscompares++; $display("FAIL drop_ready[%0d]: got %b expected %b", n, obs_ready, exp_ready); end
            if (bus.id_o !== 2'(ids[n])) begin miscompares++; $display("FAIL drop_id[%0d]: got %0d expected %0d", n, bus.id_o, ids[n]); end
        end
    endtask

    task automatic test_mid_reset();
        set_bases(32'h100);
        do_reset();
        step(4'hF, 1'b1);
        step(4'hF, 1'b1);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        vectors += 2;
        if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL midreset_valid: got %0b expected 0", bus.valid); end
        if (bus.req_ready !== '0) begin miscompares++; $display("FAIL midreset_ready: got %b expected 0000", bus.req_ready); end
        @(negedge clock);
        bus.req_valid = '0;
        reset = 1'b0;
        model_reset();
        step(4'hF, 1'b1);
        vectors += 2;
        if (bus.id_o !== 2'd0) begin miscompares++; $display("FAIL midreset_restart_id: got %0d expected 0", bus.id_o); end
        if (bus.dat_o !== 32'h0) begin miscompares++; $display("FAIL midreset_restart_dat: got %0h expected 0", bus.dat_o); end
    endtask

    task automatic test_random();
        set_bases(32'h1000);
        do_reset();
        for (int n = 0; n < 300; n++) begin
            step(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            vectors += 2;
            if (obs_ready !== exp_ready) begin miscompares++; $display("FAIL rand_ready[%0d]: got %b expected %b", n, obs_ready, exp_ready); end
            if (bus.valid !== m_valid) begin miscompares++; $display("FAIL rand_valid[%0d]: got %0b expected %0b", n, bus.valid, m_valid); end
            if (m_valid) begin
                vectors += 2;
                if (bus.dat_o !== m_dat) begin miscompares++; $display("FAIL rand_dat[%0d]: got %0h expected %0h", n, bus.dat_o, m_dat); end
                if (bus.id_o !== 2'(m_id)) begin miscompares++; $display("FAIL rand_id[%0d]: got %0d expected %0d", n, bus.id_o, m_id); end
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b0;
        bus.req_valid = '0;
        bus.req_dat = '0;
        bus.ready = 1'b0;
        model_reset();
        test_reset();
        test_contention();
        test_single();
        test_backpressure();
        test_owner_drop();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
